// File: rtl/sid_cycle_sequencer_pkg.sv
// Shared types and defaults for the SID frame scheduler and its consumers.
// Cycle counters are 5 bits wide, so each phase can run at most 31 cycles.
package sid;

   typedef logic [4:0] cycle_t;

   typedef enum logic [1:0] {
      IDLE,
      VOICE,
      FILTER
   } seq_state_t;

   localparam int SID_VOICE_CYCLES  = 12;
   localparam int SID_FILTER_CYCLES = 10;
   localparam int SID_CYCLE_MAX     = (2 ** $bits(cycle_t)) - 1;

endpackage

// File: rtl/sid_sync2.sv
// Two-flop synchronizer with rising-edge detect for asynchronous bus strobes.
// The rise output is one clk wide and aligned with the first high level.
module sid_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic s1_reg;
   logic s2_reg;
   logic prev_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_reg   <= 1'b0;
         s2_reg   <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         s1_reg   <= async_in;
         s2_reg   <= s1_reg;
         prev_reg <= s2_reg;
      end
   end

   assign level = s2_reg;
   assign rise  = s2_reg & ~prev_reg;

endmodule

// File: rtl/sid_cycle_sequencer.sv
// Per-PHI2 frame scheduler: voice cycles, then filter cycles, plus a tick
// every TICK_FRAMES accepted frames for bus fade-out aging.
module sid_cycle_sequencer
   import sid::*;
#(
   parameter int VOICE_CYCLES  = SID_VOICE_CYCLES,
   parameter int FILTER_CYCLES = SID_FILTER_CYCLES,
   parameter int TICK_FRAMES   = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       phi2_pin,
   output logic       phi2,
   output logic [4:0] voice_cycle,
   output logic [4:0] filter_cycle,
   output logic       tick_ms,
   output logic       frame_active,
   output logic       overrun
);

   localparam int TICK_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
   localparam cycle_t VOICE_LAST  = cycle_t'(VOICE_CYCLES);
   localparam cycle_t FILTER_LAST = cycle_t'(FILTER_CYCLES);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_FRAMES - 1);

   if (VOICE_CYCLES < 1 || VOICE_CYCLES > SID_CYCLE_MAX) begin : g_bad_voice
      $error("VOICE_CYCLES must be in 1..%0d", SID_CYCLE_MAX);
   end
   if (FILTER_CYCLES < 1 || FILTER_CYCLES > SID_CYCLE_MAX) begin : g_bad_filter
      $error("FILTER_CYCLES must be in 1..%0d", SID_CYCLE_MAX);
   end
   if (TICK_FRAMES < 1) begin : g_bad_tick
      $error("TICK_FRAMES must be at least 1");
   end

   seq_state_t        state_reg;
   cycle_t            voice_cycle_reg;
   cycle_t            filter_cycle_reg;
   logic [TICK_W-1:0] tick_cnt_reg;
   logic              tick_ms_reg;
   logic              overrun_reg;
   logic              rise;
   logic              accept;

   sid_sync2 u_phi2_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (phi2_pin),
      .level    (phi2),
      .rise     (rise)
   );

   // A rise landing on the final filter cycle chains straight into the next frame.
   assign accept = rise & ((state_reg == IDLE) ||
                           ((state_reg == FILTER) && (filter_cycle_reg == FILTER_LAST)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         voice_cycle_reg  <= '0;
         filter_cycle_reg <= '0;
         tick_cnt_reg     <= '0;
         tick_ms_reg      <= 1'b0;
         overrun_reg      <= 1'b0;
      end else begin
         tick_ms_reg <= 1'b0;
         if (accept) begin
            state_reg        <= VOICE;
            voice_cycle_reg  <= cycle_t'(1);
            filter_cycle_reg <= '0;
            tick_ms_reg      <= (tick_cnt_reg == TICK_LAST);
            tick_cnt_reg     <= (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
         end else begin
            unique case (state_reg)
               IDLE: begin
                  voice_cycle_reg  <= '0;
                  filter_cycle_reg <= '0;
               end
               VOICE: begin
                  if (voice_cycle_reg == VOICE_LAST) begin
                     voice_cycle_reg  <= '0;
                     filter_cycle_reg <= cycle_t'(1);
                     state_reg        <= FILTER;
                  end else begin
                     voice_cycle_reg <= voice_cycle_reg + cycle_t'(1);
                  end
               end
               FILTER: begin
                  if (filter_cycle_reg == FILTER_LAST) begin
                     filter_cycle_reg <= '0;
                     state_reg        <= IDLE;
                  end else begin
                     filter_cycle_reg <= filter_cycle_reg + cycle_t'(1);
                  end
               end
               default: begin
                  state_reg        <= IDLE;
                  voice_cycle_reg  <= '0;
                  filter_cycle_reg <= '0;
               end
            endcase
         end
         if (rise && !accept) begin
            overrun_reg <= 1'b1;
         end
      end
   end

   assign voice_cycle  = voice_cycle_reg;
   assign filter_cycle = filter_cycle_reg;
   assign tick_ms      = tick_ms_reg;
   assign overrun      = overrun_reg;
   assign frame_active = (voice_cycle_reg != '0) || (filter_cycle_reg != '0);

endmodule

// File: tb/tb_sid_cycle_sequencer.sv
// Directed bench for sid_cycle_sequencer with TICK_FRAMES = 4.
// Outputs are sampled 1 ns after each rising clk edge.
module tb_sid_cycle_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       phi2_pin;
   logic       phi2;
   logic [4:0] voice_cycle;
   logic [4:0] filter_cycle;
   logic       tick_ms;
   logic       frame_active;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   sid_cycle_sequencer #(
      .VOICE_CYCLES  (12),
      .FILTER_CYCLES (10),
      .TICK_FRAMES   (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .phi2_pin     (phi2_pin),
      .phi2         (phi2),
      .voice_cycle  (voice_cycle),
      .filter_cycle (filter_cycle),
      .tick_ms      (tick_ms),
      .frame_active (frame_active),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish within 2 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n    = 1'b0;
      phi2_pin = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      total++;
      if ({phi2, voice_cycle, filter_cycle, tick_ms, frame_active, overrun} !== 14'd0) begin
         bad++;
         $display("FAIL apply_reset_outs: got %b required all zero",
                  {phi2, voice_cycle, filter_cycle, tick_ms, frame_active, overrun});
      end
   endtask

   // Periodic PHI2 of the given period for n rises; gathers frame statistics.
   task automatic run_phi2(input int period, input int n_rises,
                           output int starts, output int ticks, output int bad_tick,
                           output int active, output int b2b, output int overlap);
      logic [4:0] prev_filter;
      starts = 0; ticks = 0; bad_tick = 0; active = 0; b2b = 0; overlap = 0;
      prev_filter = '0;
      for (int c = 0; c < period * n_rises + 30; c++) begin
         phi2_pin = (c < period * n_rises) && ((c % period) < (period / 2));
         step();
         if (voice_cycle == 5'd1) begin
            starts++;
            if (prev_filter == 5'd10) b2b++;
         end
         if (tick_ms && (voice_cycle !== 5'd1 || (starts % 4) != 0)) bad_tick++;
         if (tick_ms) ticks++;
         if (frame_active) active++;
         if (voice_cycle != 5'd0 && filter_cycle != 5'd0) overlap++;
         prev_filter = filter_cycle;
      end
      phi2_pin = 1'b0;
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      phi2_pin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         phi2_pin = ~phi2_pin;
         step();
         total++;
         if ({phi2, voice_cycle, filter_cycle, tick_ms, frame_active, overrun} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outs cycle %0d: got %b required all zero", i,
                     {phi2, voice_cycle, filter_cycle, tick_ms, frame_active, overrun});
         end
      end
      phi2_pin = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (frame_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_frame cycle %0d: got frame_active=%b required 0", i, frame_active);
         end
      end
   endtask

   task automatic test_single;
      int act;
      act = 0;
      phi2_pin = 1'b1;
      step();
      total++;
      if (frame_active !== 1'b0) begin
         bad++;
         $display("FAIL single_lat0: got frame_active=%b required 0", frame_active);
      end
      step();
      total++;
      if (phi2 !== 1'b1 || frame_active !== 1'b0) begin
         bad++;
         $display("FAIL single_lat1: got phi2=%b frame_active=%b required phi2=1 frame_active=0",
                  phi2, frame_active);
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         if (i == 4) phi2_pin = 1'b0;
         if (frame_active) act++;
         total++;
         if (voice_cycle !== i[4:0] || filter_cycle !== 5'd0) begin
            bad++;
            $display("FAIL single_voice: got voice=%0d filter=%0d required voice=%0d filter=0",
                     voice_cycle, filter_cycle, i);
         end
         if (i == 1) begin
            total++;
            if (tick_ms !== 1'b0) begin
               bad++;
               $display("FAIL single_tick: got tick_ms=%b required 0 on first frame", tick_ms);
            end
         end
      end
      for (int j = 1; j <= 10; j++) begin
         step();
         if (frame_active) act++;
         total++;
         if (filter_cycle !== j[4:0] || voice_cycle !== 5'd0) begin
            bad++;
            $display("FAIL single_filter: got voice=%0d filter=%0d required voice=0 filter=%0d",
                     voice_cycle, filter_cycle, j);
         end
      end
      step();
      total++;
      if (voice_cycle !== 5'd0 || filter_cycle !== 5'd0 || frame_active !== 1'b0) begin
         bad++;
         $display("FAIL single_end: got voice=%0d filter=%0d active=%b required all 0",
                  voice_cycle, filter_cycle, frame_active);
      end
      total++;
      if (act != 22) begin
         bad++;
         $display("FAIL single_active_len: got %0d required 22", act);
      end
   endtask

   task automatic test_tick;
      int st, tk, btk, act, b2b, ovl;
      apply_reset();
      run_phi2(24, 12, st, tk, btk, act, b2b, ovl);
      total++;
      if (st != 12 || tk != 3 || btk != 0) begin
         bad++;
         $display("FAIL tick_pulses: got frames=%0d ticks=%0d misplaced=%0d required 12 3 0",
                  st, tk, btk);
      end
      total++;
      if (overrun !== 1'b0 || act != 12 * 22 || ovl != 0) begin
         bad++;
         $display("FAIL tick_frames: got overrun=%b active=%0d overlap=%0d required 0 264 0",
                  overrun, act, ovl);
      end
   endtask

   task automatic test_overrun;
      int st, tk, btk, act, b2b, ovl;
      apply_reset();
      run_phi2(15, 8, st, tk, btk, act, b2b, ovl);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_flag: got %b required 1", overrun);
      end
      total++;
      if (st != 4 || act != 4 * 22 || ovl != 0) begin
         bad++;
         $display("FAIL overrun_frames: got frames=%0d active=%0d overlap=%0d required 4 88 0",
                  st, act, ovl);
      end
      total++;
      if (tk != 1 || btk != 0) begin
         bad++;
         $display("FAIL overrun_tick: got ticks=%0d misplaced=%0d required 1 0", tk, btk);
      end
   endtask

   task automatic test_back_to_back;
      int st, tk, btk, act, b2b, ovl;
      apply_reset();
      run_phi2(24, 4, st, tk, btk, act, b2b, ovl);
      total++;
      if (st != 4 || overrun !== 1'b0 || b2b != 0) begin
         bad++;
         $display("FAIL period24: got frames=%0d overrun=%b chained=%0d required 4 0 0",
                  st, overrun, b2b);
      end
      apply_reset();
      run_phi2(22, 5, st, tk, btk, act, b2b, ovl);
      total++;
      if (st != 5 || overrun !== 1'b0 || b2b != 4) begin
         bad++;
         $display("FAIL back_to_back: got frames=%0d overrun=%b chained=%0d required 5 0 4",
                  st, overrun, b2b);
      end
      total++;
      if (act != 5 * 22 || ovl != 0 || tk != 1 || btk != 0) begin
         bad++;
         $display("FAIL back_to_back_len: got active=%0d overlap=%0d ticks=%0d misplaced=%0d required 110 0 1 0",
                  act, ovl, tk, btk);
      end
   endtask

   task automatic test_reset_midframe;
      bit found;
      found = 1'b0;
      apply_reset();
      phi2_pin = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (voice_cycle == 5'd1) phi2_pin = 1'b0;
         if (voice_cycle == 5'd3) phi2_pin = 1'b1;
         if (voice_cycle == 5'd7) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL midframe_wait: got no voice_cycle=7 within 40 clks required it");
      end
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL midframe_overrun: got %b required 1 before reset", overrun);
      end
      rst_n    = 1'b0;
      phi2_pin = 1'b0;
      step();
      total++;
      if ({phi2, voice_cycle, filter_cycle, tick_ms, frame_active, overrun} !== 14'd0) begin
         bad++;
         $display("FAIL midframe_reset: got %b required all zero",
                  {phi2, voice_cycle, filter_cycle, tick_ms, frame_active, overrun});
      end
      rst_n = 1'b1;
      repeat (3) step();
      total++;
      if (frame_active !== 1'b0) begin
         bad++;
         $display("FAIL midframe_resume: got frame_active=%b required 0", frame_active);
      end
      phi2_pin = 1'b1;
      repeat (3) step();
      total++;
      if (voice_cycle !== 5'd1 || filter_cycle !== 5'd0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL midframe_restart: got voice=%0d filter=%0d overrun=%b required 1 0 0",
                  voice_cycle, filter_cycle, overrun);
      end
      phi2_pin = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      phi2_pin = 1'b0;
      test_reset();
      test_single();
      test_tick();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
